// File: rtl/des3_round_controller.sv
// -----------------------------------------------------------------------------
// des3_round_controller
//   Sequencing FSM for an iterative triple-DES (EDE) datapath. One accepted
//   start runs LOAD (initial permutation) followed by 3 stages x 16 Feistel
//   rounds, then holds the result valid until the consumer accepts it.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   start        in   begin one 64-bit block; honoured only in IDLE
//   is_encrypt   in   direction, captured on an accepted start
//   round_keys_1 in   stage-0 round keys [0:15][0:47]
//   round_keys_2 in   stage-1 round keys, consumed in reverse order
//   round_keys_3 in   stage-2 round keys [0:15][0:47]
//   busy         out  high in LOAD and ROUND
//   load_in      out  one-cycle pulse: datapath captures block, applies IP
//   round_en     out  datapath performs one Feistel round this cycle
//   round_key    out  key for the current round, zero when round_en is low
//   stage        out  current stage 0..2
//   round        out  current round 0..15 within the stage
//   stage_end    out  last round of a stage: datapath skips the L/R swap
//   out_valid    out  result available
//   out_ready    in   consumer accepts the result
// -----------------------------------------------------------------------------
module des3_round_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_encrypt,
  input  logic [0:15][0:47] round_keys_1,
  input  logic [0:15][0:47] round_keys_2,
  input  logic [0:15][0:47] round_keys_3,
  output logic        busy,
  output logic        load_in,
  output logic        round_en,
  output logic [0:47] round_key,
  output logic [1:0]  stage,
  output logic [3:0]  round,
  output logic        stage_end,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned NUM_STAGES = 3;
  localparam int unsigned NUM_ROUNDS = 16;
  localparam int unsigned KEY_W      = 48;
  localparam int unsigned STAGE_W    = 2;
  localparam int unsigned ROUND_W    = 4;

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e               state_q;
  logic                 dir_q;
  logic [STAGE_W-1:0]   stage_q;
  logic [ROUND_W-1:0]   round_q;
  logic                 busy_q;
  logic                 load_in_q;
  logic                 round_en_q;
  logic                 stage_end_q;
  logic                 out_valid_q;
  logic [0:KEY_W-1]     key_sel_c;

  // Controller FSM; every output except round_key is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      stage_q     <= '0;
      round_q     <= '0;
      busy_q      <= 1'b0;
      load_in_q   <= 1'b0;
      round_en_q  <= 1'b0;
      stage_end_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dir_q     <= is_encrypt;
            stage_q   <= '0;
            round_q   <= '0;
            busy_q    <= 1'b1;
            load_in_q <= 1'b1;
            state_q   <= S_LOAD;
          end
        end

        S_LOAD: begin
          load_in_q  <= 1'b0;
          round_en_q <= 1'b1;
          state_q    <= S_ROUND;
        end

        S_ROUND: begin
          if (round_q == LAST_ROUND) begin
            stage_end_q <= 1'b0;
            if (stage_q == LAST_STAGE) begin
              // 48th round just ran: stop before a 49th round_en.
              round_en_q  <= 1'b0;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              stage_q <= stage_q + STAGE_W'(1);
              round_q <= '0;
            end
          end else begin
            round_q     <= round_q + ROUND_W'(1);
            // Flag arrives together with round 15 of the stage.
            stage_end_q <= (round_q == LAST_ROUND - ROUND_W'(1));
          end
        end

        S_DONE: begin
          // Starts seen here are dropped; only the handshake completes.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Round key mux straight off the registered stage/round; the middle (decrypt)
  // pass of EDE walks its schedule backwards.
  always_comb begin
    key_sel_c = '0;
    if (round_en_q) begin
      case (stage_q)
        2'd0:    key_sel_c = round_keys_1[round_q];
        2'd1:    key_sel_c = round_keys_2[LAST_ROUND - round_q];
        2'd2:    key_sel_c = round_keys_3[round_q];
        default: key_sel_c = '0;
      endcase
    end
  end

  // Captured direction must stay frozen for the whole block.
  dir_frozen_a: assert property (@(posedge clk)
    (!rst && !(state_q == S_IDLE && start)) |=> $stable(dir_q));

  assign busy      = busy_q;
  assign load_in   = load_in_q;
  assign round_en  = round_en_q;
  assign round_key = key_sel_c;
  assign stage     = stage_q;
  assign round     = round_q;
  assign stage_end = stage_end_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_des3_round_controller.sv
// -----------------------------------------------------------------------------
// tb_des3_round_controller
//   Directed bench for des3_round_controller. Inputs change and outputs are
//   sampled on the falling edge. Cycle c counts falling edges after the rising
//   edge that accepted start (c=1 LOAD, c=2..49 rounds, c=50 DONE).
// -----------------------------------------------------------------------------
module tb_des3_round_controller;

  logic              clk;
  logic              rst;
  logic              start;
  logic              is_encrypt;
  logic [0:15][0:47] rk1;
  logic [0:15][0:47] rk2;
  logic [0:15][0:47] rk3;
  logic              busy;
  logic              load_in;
  logic              round_en;
  logic [0:47]       round_key;
  logic [1:0]        stage;
  logic [3:0]        round;
  logic              stage_end;
  logic              out_valid;
  logic              out_ready;

  int checks;
  int errors;

  // {load_in, busy, round_en, stage_end, out_valid, stage, round, round_key}
  localparam logic [58:0] MASK_ALL   = {59{1'b1}};
  localparam logic [58:0] MASK_NOPOS = {5'h1F, 6'h00, 48'hFFFF_FFFF_FFFF};

  des3_round_controller dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .is_encrypt   (is_encrypt),
    .round_keys_1 (rk1),
    .round_keys_2 (rk2),
    .round_keys_3 (rk3),
    .busy         (busy),
    .load_in      (load_in),
    .round_en     (round_en),
    .round_key    (round_key),
    .stage        (stage),
    .round        (round),
    .stage_end    (stage_end),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [58:0] obs();
    return {load_in, busy, round_en, stage_end, out_valid, stage, round, round_key};
  endfunction

  // Expected outputs c cycles after the accepting edge (c>=51 means back in IDLE).
  // Keys: rk1[k]=0x100+k, rk2[k]=k (so stage 1 yields 15-r), rk3[k]=0x300+k.
  function automatic logic [58:0] exp_vec(input int c);
    int         i;
    int         rr;
    logic [1:0] s;
    logic [3:0] r;
    logic [47:0] k;
    exp_vec = '0;
    if (c == 1) begin
      exp_vec = {5'b11000, 6'b0, 48'b0};
    end else if (c >= 2 && c <= 49) begin
      i  = c - 2;
      rr = i % 16;
      s  = 2'(i / 16);
      r  = 4'(rr);
      case (s)
        2'd0:    k = 48'(256 + rr);
        2'd1:    k = 48'(15 - rr);
        default: k = 48'(768 + rr);
      endcase
      exp_vec = {1'b0, 1'b1, 1'b1, (rr == 15), 1'b0, s, r, k};
    end else if (c == 50) begin
      exp_vec = {5'b00001, 6'b0, 48'b0};
    end
  endfunction

  function automatic logic [58:0] exp_mask(input int c);
    return (c >= 50) ? MASK_NOPOS : MASK_ALL;
  endfunction

  task automatic test_reset();
    logic [58:0] e;
    logic [58:0] m;
    rst = 1'b1; start = 1'b1; is_encrypt = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    if (obs() !== 59'd0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", obs(), 59'd0);
    end
    checks++;
    // start held across reset release: accepted on the first edge with rst=0
    rst = 1'b0;
    for (int c = 1; c <= 51; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      e = exp_vec(c); m = exp_mask(c);
      if ((obs() & m) !== (e & m)) begin
        errors++;
        $display("FAIL first_start c=%0d got=%h exp=%h", c, obs() & m, e & m);
      end
      checks++;
    end
  endtask

  task automatic test_basic_run();
    logic [58:0] e;
    logic [58:0] m;
    int n_re;
    int n_se;
    n_re = 0; n_se = 0;
    start = 1'b1; out_ready = 1'b1; is_encrypt = 1'b0;
    for (int c = 1; c <= 51; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (round_en) n_re++;
      if (stage_end) n_se++;
      e = exp_vec(c); m = exp_mask(c);
      if ((obs() & m) !== (e & m)) begin
        errors++;
        $display("FAIL basic_run c=%0d got=%h exp=%h", c, obs() & m, e & m);
      end
      checks++;
    end
    if (n_re !== 48) begin
      errors++;
      $display("FAIL round_en_count got=%0d exp=48", n_re);
    end
    checks++;
    if (n_se !== 3) begin
      errors++;
      $display("FAIL stage_end_count got=%0d exp=3", n_se);
    end
    checks++;
  endtask

  task automatic test_backpressure();
    logic [58:0] e;
    logic [58:0] m;
    start = 1'b1; out_ready = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      e = (c >= 50) ? exp_vec(50) : exp_vec(c);
      m = exp_mask(c);
      if ((obs() & m) !== (e & m)) begin
        errors++;
        $display("FAIL backpressure c=%0d got=%h exp=%h", c, obs() & m, e & m);
      end
      checks++;
      // start together with out_ready in DONE: handshake only
      if (c == 60) begin out_ready = 1'b1; start = 1'b1; end
    end
    @(negedge clk);
    e = exp_vec(51);
    if ((obs() & MASK_NOPOS) !== (e & MASK_NOPOS)) begin
      errors++;
      $display("FAIL handshake_idle got=%h exp=%h", obs() & MASK_NOPOS, e & MASK_NOPOS);
    end
    checks++;
    // start still high: accepted from IDLE now
    for (int c = 1; c <= 51; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      e = exp_vec(c); m = exp_mask(c);
      if ((obs() & m) !== (e & m)) begin
        errors++;
        $display("FAIL restart_after_done c=%0d got=%h exp=%h", c, obs() & m, e & m);
      end
      checks++;
    end
  endtask

  task automatic test_start_ignored();
    logic [58:0] e;
    logic [58:0] m;
    start = 1'b1; out_ready = 1'b0;
    for (int c = 1; c <= 53; c++) begin
      @(negedge clk);
      if (c == 2 || c == 24) start = 1'b0;
      e = (c == 51) ? exp_vec(50) : exp_vec(c);
      m = exp_mask(c);
      if ((obs() & m) !== (e & m)) begin
        errors++;
        $display("FAIL start_ignored c=%0d got=%h exp=%h", c, obs() & m, e & m);
      end
      checks++;
      if (c == 23) start = 1'b1;          // stage 1, round 5
      if (c == 50) start = 1'b1;          // in DONE, out_ready low
      if (c == 51) begin start = 1'b0; out_ready = 1'b1; end
    end
  endtask

  task automatic test_reset_mid();
    logic [58:0] e;
    logic [58:0] m;
    start = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      e = exp_vec(c);
      if (obs() !== e) begin
        errors++;
        $display("FAIL pre_reset c=%0d got=%h exp=%h", c, obs(), e);
      end
      checks++;
    end
    rst = 1'b1;                            // stage 1, round 7
    @(negedge clk);
    if (obs() !== 59'd0) begin
      errors++;
      $display("FAIL reset_mid_round got=%h exp=%h", obs(), 59'd0);
    end
    checks++;
    rst = 1'b0; start = 1'b1;
    for (int c = 1; c <= 51; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      e = exp_vec(c); m = exp_mask(c);
      if ((obs() & m) !== (e & m)) begin
        errors++;
        $display("FAIL after_reset c=%0d got=%h exp=%h", c, obs() & m, e & m);
      end
      checks++;
    end
    // reset while a result is pending in DONE discards it
    start = 1'b1; out_ready = 1'b0;
    for (int c = 1; c <= 52; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL done_pending got=%b exp=1", out_valid);
    end
    checks++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (obs() !== 59'd0) begin
      errors++;
      $display("FAIL reset_in_done got=%h exp=%h", obs(), 59'd0);
    end
    checks++;
    @(negedge clk);
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL result_discarded got=%b exp=0", out_valid);
    end
    checks++;
    out_ready = 1'b1;
  endtask

  task automatic test_dir_toggle();
    logic [58:0] e;
    logic [58:0] m;
    is_encrypt = 1'b1; start = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 51; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      is_encrypt = ~is_encrypt;
      e = exp_vec(c); m = exp_mask(c);
      if ((obs() & m) !== (e & m)) begin
        errors++;
        $display("FAIL dir_toggle c=%0d got=%h exp=%h", c, obs() & m, e & m);
      end
      checks++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; start = 1'b0; is_encrypt = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      rk1[k] = 48'(256 + k);
      rk2[k] = 48'(k);
      rk3[k] = 48'(768 + k);
    end
    test_reset();
    test_basic_run();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_dir_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
